// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

  localparam int NUM_REGS   = 16;
  localparam int REG_IDX_W  = 4;
  localparam int PC_WIDTH   = 16;
  localparam int CNT_W      = 2;
  localparam int BR_TIMEOUT = 15;
  localparam int TMO_W      = $clog2(BR_TIMEOUT + 1);

  typedef enum logic [1:0] {
    BR_IDLE     = 2'd0,
    BR_WAIT     = 2'd1,
    BR_REDIRECT = 2'd2
  } br_state_t;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [PC_WIDTH-1:0]  pc_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of decode/memory/writeback inputs and fetch/decode control outputs.
// Latency: n/a (wiring only).
// Backpressure: stall outputs travel back to fetch/decode through this bundle.
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  logic     I_DE_Valid;
  logic     I_DE_IsBranch;
  logic     I_DE_DestValid;
  reg_idx_t I_DE_DestReg;
  logic     I_DE_Src1Valid;
  reg_idx_t I_DE_Src1Reg;
  logic     I_DE_Src2Valid;
  reg_idx_t I_DE_Src2Reg;
  logic     I_MEM_BranchResolved;
  logic     I_MEM_BranchTaken;
  pc_t      I_MEM_BranchTarget;
  logic     I_WB_Valid;
  reg_idx_t I_WB_DestReg;
  logic     O_DepStallSignal;
  logic     O_BranchStallSignal;
  logic     O_BranchAddrSelect;
  pc_t      O_BranchPC;
  logic     O_Error;

  // Pipeline side: drives decode/mem/wb info, consumes stall/redirect.
  modport master (
    output I_DE_Valid, I_DE_IsBranch, I_DE_DestValid, I_DE_DestReg,
           I_DE_Src1Valid, I_DE_Src1Reg, I_DE_Src2Valid, I_DE_Src2Reg,
           I_MEM_BranchResolved, I_MEM_BranchTaken, I_MEM_BranchTarget,
           I_WB_Valid, I_WB_DestReg,
    input  O_DepStallSignal, O_BranchStallSignal, O_BranchAddrSelect,
           O_BranchPC, O_Error
  );

  // Controller side.
  modport slave (
    input  I_DE_Valid, I_DE_IsBranch, I_DE_DestValid, I_DE_DestReg,
           I_DE_Src1Valid, I_DE_Src1Reg, I_DE_Src2Valid, I_DE_Src2Reg,
           I_MEM_BranchResolved, I_MEM_BranchTaken, I_MEM_BranchTarget,
           I_WB_Valid, I_WB_DestReg,
    output O_DepStallSignal, O_BranchStallSignal, O_BranchAddrSelect,
           O_BranchPC, O_Error
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_reg_scoreboard.sv
// Per-register count of in-flight writers with one increment, one decrement and three read ports.
// Latency: reads are combinational; updates land on the next clock edge.
// Backpressure: none; saturates at max and floors at zero, flagging a zero-floor decrement.
module reg_scoreboard #(
  parameter int N     = 16,
  parameter int IDX_W = 4,
  parameter int W     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_vld,
  input  logic [IDX_W-1:0] inc_idx,
  input  logic             dec_vld,
  input  logic [IDX_W-1:0] dec_idx,
  input  logic [IDX_W-1:0] rd1_idx,
  input  logic [IDX_W-1:0] rd2_idx,
  input  logic [IDX_W-1:0] rd3_idx,
  output logic [W-1:0]     rd1_cnt,
  output logic [W-1:0]     rd2_cnt,
  output logic [W-1:0]     rd3_cnt,
  output logic             underflow
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [N-1:0][W-1:0] cnt;
  logic                same_reg;

  assign rd1_cnt  = cnt[rd1_idx];
  assign rd2_cnt  = cnt[rd2_idx];
  assign rd3_cnt  = cnt[rd3_idx];
  // An inc and dec on the same register cancel, so that case is never an underflow.
  assign same_reg  = inc_vld & dec_vld & (inc_idx == dec_idx);
  assign underflow = dec_vld & (cnt[dec_idx] == '0) & ~same_reg;

  // Counter update: inc/dec on one register cancel; saturate high, floor at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      for (int r = 0; r < N; r++) begin
        if (inc_vld && inc_idx == IDX_W'(r) && !(dec_vld && dec_idx == IDX_W'(r))) begin
          if (cnt[r] != CNT_MAX) cnt[r] <= cnt[r] + 1'b1;
        end else if (dec_vld && dec_idx == IDX_W'(r) && !(inc_vld && inc_idx == IDX_W'(r))) begin
          if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central dependency-stall and branch-redirect controller beside decode.
// Latency: stalls are combinational on decode inputs; redirect appears the cycle after resolve.
// Backpressure: holds decode while a source is pending or dest counter is full; stops fetch while a branch is outstanding.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input logic                  I_CLOCK,
  input logic                  I_LOCK,
  pipeline_hazard_ctrl_if.slave hif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  br_state_t        state;
  logic [TMO_W-1:0] tmo;
  pc_t              br_pc;
  logic             addr_sel;
  logic             err;

  logic [CNT_W-1:0] src1_cnt;
  logic [CNT_W-1:0] src2_cnt;
  logic [CNT_W-1:0] dest_cnt;
  logic             sb_underflow;
  logic             dep_stall;
  logic             issue;
  logic             br_issue;
  logic             spurious_res;
  logic             tmo_hit;

  reg_scoreboard #(
    .N     (NUM_REGS),
    .IDX_W (REG_IDX_W),
    .W     (CNT_W)
  ) u_sb (
    .clk       (I_CLOCK),
    .rst_n     (I_LOCK),
    .inc_vld   (issue & hif.I_DE_DestValid),
    .inc_idx   (hif.I_DE_DestReg),
    .dec_vld   (hif.I_WB_Valid),
    .dec_idx   (hif.I_WB_DestReg),
    .rd1_idx   (hif.I_DE_Src1Reg),
    .rd2_idx   (hif.I_DE_Src2Reg),
    .rd3_idx   (hif.I_DE_DestReg),
    .rd1_cnt   (src1_cnt),
    .rd2_cnt   (src2_cnt),
    .rd3_cnt   (dest_cnt),
    .underflow (sb_underflow)
  );

  // Retirement this cycle is not bypassed: the stall drops only once the counter has updated.
  assign dep_stall = hif.I_DE_Valid &
                     ((hif.I_DE_Src1Valid & (src1_cnt != '0)) |
                      (hif.I_DE_Src2Valid & (src2_cnt != '0)) |
                      (hif.I_DE_DestValid & (dest_cnt == CNT_MAX)));

  assign issue        = hif.I_DE_Valid & ~dep_stall & (state != BR_WAIT);
  assign br_issue     = issue & hif.I_DE_IsBranch;
  assign spurious_res = hif.I_MEM_BranchResolved & (state != BR_WAIT);
  assign tmo_hit      = (state == BR_WAIT) & ~hif.I_MEM_BranchResolved &
                        (tmo == TMO_W'(BR_TIMEOUT));

  // Branch sequencing with registered redirect outputs and sticky error.
  always_ff @(posedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      state    <= BR_IDLE;
      tmo      <= '0;
      br_pc    <= '0;
      addr_sel <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= err | sb_underflow | spurious_res | tmo_hit;
      case (state)
        BR_IDLE: begin
          if (br_issue) begin
            state <= BR_WAIT;
            tmo   <= '0;
          end
        end
        BR_WAIT: begin
          if (hif.I_MEM_BranchResolved) begin
            if (hif.I_MEM_BranchTaken) begin
              state    <= BR_REDIRECT;
              br_pc    <= hif.I_MEM_BranchTarget;
              addr_sel <= 1'b1;
            end else begin
              state <= BR_IDLE;
            end
          end else if (!tmo_hit) begin
            tmo <= tmo + 1'b1;
          end
        end
        BR_REDIRECT: begin
          state    <= BR_IDLE;
          addr_sel <= 1'b0;
        end
        default: begin
          state    <= BR_IDLE;
          addr_sel <= 1'b0;
        end
      endcase
    end
  end

  assign hif.O_DepStallSignal    = dep_stall;
  assign hif.O_BranchStallSignal = (state == BR_WAIT) | br_issue;
  assign hif.O_BranchAddrSelect  = addr_sel;
  assign hif.O_BranchPC          = br_pc;
  assign hif.O_Error             = err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: driver pushes expected outputs from a behavioural model, monitor compares at negedge.
// Latency: expectations are per-cycle, popped half a cycle after inputs are applied.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  logic clk  = 1'b0;
  logic lock = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hif ();

  pipeline_hazard_ctrl dut (
    .I_CLOCK (clk),
    .I_LOCK  (lock),
    .hif     (hif)
  );

  typedef struct {
    bit        lock;
    bit        v;
    bit        br;
    bit        dv;
    bit [3:0]  d;
    bit        s1v;
    bit [3:0]  s1;
    bit        s2v;
    bit [3:0]  s2;
    bit        res;
    bit        tk;
    bit [15:0] tgt;
    bit        wbv;
    bit [3:0]  wb;
  } stim_t;

  typedef struct {
    bit        dep;
    bit        brst;
    bit        sel;
    bit [15:0] pc;
    bit        err;
    bit [31:0] cnts;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: pending-writer counts plus a description of the branch situation.
  int        m_cnt[16];
  bit        m_wait;
  bit        m_redir;
  int        m_age;
  bit [15:0] m_pc;
  bit        m_err;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.lock = 1'b1;
    return s;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++) m_cnt[r] = 0;
    m_wait  = 0;
    m_redir = 0;
    m_age   = 0;
    m_pc    = 16'h0;
    m_err   = 0;
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    bit   issue;
    @(posedge clk);
    #1;
    lock                     = s.lock;
    hif.I_DE_Valid           = s.v;
    hif.I_DE_IsBranch        = s.br;
    hif.I_DE_DestValid       = s.dv;
    hif.I_DE_DestReg         = s.d;
    hif.I_DE_Src1Valid       = s.s1v;
    hif.I_DE_Src1Reg         = s.s1;
    hif.I_DE_Src2Valid       = s.s2v;
    hif.I_DE_Src2Reg         = s.s2;
    hif.I_MEM_BranchResolved = s.res;
    hif.I_MEM_BranchTaken    = s.tk;
    hif.I_MEM_BranchTarget   = s.tgt;
    hif.I_WB_Valid           = s.wbv;
    hif.I_WB_DestReg         = s.wb;
    if (!s.lock) model_reset();

    e.dep  = s.v && ((s.s1v && m_cnt[s.s1] > 0) || (s.s2v && m_cnt[s.s2] > 0) ||
                     (s.dv && m_cnt[s.d] == 3));
    issue  = s.v && !e.dep && !m_wait;
    e.brst = m_wait || (issue && s.br);
    e.sel  = m_redir;
    e.pc   = m_pc;
    e.err  = m_err;
    for (int r = 0; r < 16; r++) e.cnts[r*2 +: 2] = 2'(m_cnt[r]);
    q.push_back(e);

    if (s.lock) begin
      if (!(issue && s.dv && s.wbv && s.d == s.wb)) begin
        if (issue && s.dv && m_cnt[s.d] < 3) m_cnt[s.d]++;
        if (s.wbv) begin
          if (m_cnt[s.wb] > 0) m_cnt[s.wb]--;
          else m_err = 1;
        end
      end
      if (m_wait) begin
        if (s.res) begin
          m_wait = 0;
          if (s.tk) begin
            m_redir = 1;
            m_pc    = s.tgt;
          end
        end else if (m_age == BR_TIMEOUT) begin
          m_err = 1;
        end else begin
          m_age++;
        end
      end else begin
        if (s.res) m_err = 1;
        if (m_redir) m_redir = 0;
        else if (issue && s.br) begin
          m_wait = 1;
          m_age  = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: compare the DUT against the oldest pending expectation each cycle.
  initial begin
    exp_t        e;
    logic [31:0] cnts;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e    = q.pop_front();
        cnts = dut.u_sb.cnt;
        chk("dep_stall",   hif.O_DepStallSignal,    e.dep);
        chk("br_stall",    hif.O_BranchStallSignal, e.brst);
        chk("addr_select", hif.O_BranchAddrSelect,  e.sel);
        chk("branch_pc",   hif.O_BranchPC,          e.pc);
        chk("error",       hif.O_Error,             e.err);
        chk("counters",    cnts,                    e.cnts);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    model_reset();
    s = idle();
    step(s);

    // Reset state, including the combinational branch stall during reset.
    s = idle(); s.lock = 0; step(s);
    s.v = 1; s.br = 1; step(s);
    s = idle(); step(s);

    // Dependency on R3: stall persists through the retire cycle, releases after it.
    s = idle(); s.v = 1; s.dv = 1; s.d = 3; step(s);
    s = idle(); s.v = 1; s.s1v = 1; s.s1 = 3; s.dv = 1; s.d = 4;
    repeat (3) step(s);
    s.wbv = 1; s.wb = 3; step(s);
    s.wbv = 0; step(s);
    s = idle(); s.wbv = 1; s.wb = 4; step(s);

    // Simultaneous issue and retire of R5 keeps the count at 1.
    s = idle(); s.v = 1; s.dv = 1; s.d = 5; step(s);
    s.wbv = 1; s.wb = 5; step(s);
    s = idle(); s.v = 1; s.s1v = 1; s.s1 = 9; s.s2v = 1; s.s2 = 10; step(s);
    s = idle(); s.wbv = 1; s.wb = 5; step(s);

    // Saturation on R7: the fourth writer stalls.
    s = idle(); s.v = 1; s.dv = 1; s.d = 7; repeat (5) step(s);
    s = idle(); s.wbv = 1; s.wb = 7; repeat (3) step(s);

    // Taken branch resolved in cycle 3.
    s = idle(); s.v = 1; s.br = 1; step(s);
    s = idle(); repeat (2) step(s);
    s.res = 1; s.tk = 1; s.tgt = 16'h0040; step(s);
    s = idle(); repeat (2) step(s);

    // Not-taken branch.
    s = idle(); s.v = 1; s.br = 1; step(s);
    s = idle(); repeat (2) step(s);
    s.res = 1; s.tk = 0; s.tgt = 16'h1234; step(s);
    s = idle(); repeat (2) step(s);

    // Spurious resolve in IDLE sets a sticky error.
    s = idle(); s.res = 1; s.tk = 1; s.tgt = 16'hBEEF; step(s);
    s = idle(); repeat (3) step(s);

    // Reset in WAIT with a pending writer.
    s = idle(); s.v = 1; s.br = 1; s.dv = 1; s.d = 2; step(s);
    s = idle(); step(s);
    s.lock = 0; step(s);
    s = idle(); repeat (2) step(s);

    // Reset in REDIRECT.
    s = idle(); s.v = 1; s.br = 1; step(s);
    s = idle(); s.res = 1; s.tk = 1; s.tgt = 16'h0ABC; step(s);
    s = idle(); s.lock = 0; step(s);
    s = idle(); repeat (2) step(s);

    // Branch timeout.
    s = idle(); s.v = 1; s.br = 1; step(s);
    s = idle(); repeat (19) step(s);
    s.res = 1; s.tk = 0; step(s);
    s = idle(); step(s);
    s.lock = 0; step(s);
    s = idle(); step(s);

    // Randomized traffic on a small register window.
    for (int i = 0; i < 3000; i++) begin
      int r;
      s     = idle();
      s.v   = ($urandom_range(0, 9) < 7);
      s.br  = ($urandom_range(0, 9) == 0);
      s.dv  = ($urandom_range(0, 9) < 6);
      s.d   = 4'($urandom_range(0, 7));
      s.s1v = $urandom_range(0, 1);
      s.s1  = 4'($urandom_range(0, 7));
      s.s2v = $urandom_range(0, 1);
      s.s2  = 4'($urandom_range(0, 7));
      r = $urandom_range(0, 7);
      if (m_cnt[r] > 0 && $urandom_range(0, 1) == 1) begin
        s.wbv = 1;
        s.wb  = 4'(r);
      end
      if (m_wait) s.res = ($urandom_range(0, 3) == 0);
      else        s.res = ($urandom_range(0, 99) == 0);
      s.tk  = $urandom_range(0, 1);
      s.tgt = 16'($urandom);
      if ($urandom_range(0, 399) == 0) s.lock = 0;
      step(s);
    end

    s = idle(); step(s);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall and redirect controller for the five-stage pipeline. It tracks in-flight register writers with a per-register scoreboard and sequences branch handling with a small state machine. From these it generates the dependency-stall, branch-stall, branch-address-select and branch-target signals consumed by the fetch and decode stages. It sits beside decode, takes resolution information from memory and retirement information from writeback, and replaces the scattered ad-hoc stall logic.

## Interface
- `NUM_REGS`, 16: architectural registers tracked.
- `REG_IDX_W`, 4: register index width.
- `PC_WIDTH`, 16: PC width; matches `` `PC_WIDTH ``.
- `CNT_W`, 2: per-register pending-writer counter width.
- `BR_TIMEOUT`, 15: maximum cycles in WAIT before an error is flagged.

Ports:
- `I_CLOCK`  in  1  single clock; all state updates on posedge.
- `I_LOCK`  in  1  reset, asynchronous, active-low; low clears all state.
- `I_DE_Valid`  in  1  decode holds a real (non-NOP) instruction.
- `I_DE_IsBranch`  in  1  decode instruction is a branch or jump.
- `I_DE_DestValid`, `I_DE_DestReg`  in  1, `REG_IDX_W`  decode destination.
- `I_DE_Src1Valid`, `I_DE_Src1Reg`  in  1, `REG_IDX_W`  source 1.
- `I_DE_Src2Valid`, `I_DE_Src2Reg`  in  1, `REG_IDX_W`  source 2.
- `I_MEM_BranchResolved`  in  1  one-cycle pulse: branch outcome known.
- `I_MEM_BranchTaken`  in  1  outcome; valid with Resolved.
- `I_MEM_BranchTarget`  in  `PC_WIDTH`  target; valid with Resolved.
- `I_WB_Valid`, `I_WB_DestReg`  in  1, `REG_IDX_W`  register write retiring this cycle.
- `O_DepStallSignal`  out  1  to fetch/decode: hold the FE/DE latch.
- `O_BranchStallSignal`  out  1  to fetch: stop fetching.
- `O_BranchAddrSelect`  out  1  to fetch: load `O_BranchPC`.
- `O_BranchPC`  out  `PC_WIDTH`  redirect target.
- `O_Error`  out  1  sticky protocol error.

## Operation
Issue condition: `issue = I_DE_Valid & !O_DepStallSignal & !(state==WAIT)`.

Scoreboard:
- One `CNT_W`-bit counter `cnt[r]` per register.
- Increment `cnt[I_DE_DestReg]` on `issue & I_DE_DestValid`.
- Decrement `cnt[I_WB_DestReg]` on `I_WB_Valid`.
- When the same register increments and decrements in the same cycle, it is unchanged.
- Decrementing a counter that is already 0 leaves it at 0 and sets `O_Error`.

Dependency stall (combinational):
- `O_DepStallSignal = I_DE_Valid & (S1 | S2 | D)`.
- S1: `Src1Valid & cnt[Src1Reg]!=0`.
- S2: `Src2Valid & cnt[Src2Reg]!=0`.
- D: `DestValid & cnt[DestReg]==max`; saturation stalls the instruction, never wraps.
- Retirement in the current cycle does not bypass; the stall releases the next cycle.

Branch FSM, states IDLE, WAIT, REDIRECT:
- IDLE→WAIT on `issue & I_DE_IsBranch`; the timeout counter is cleared.
- WAIT→REDIRECT on `Resolved & Taken`; latch `O_BranchPC <= Target`.
- WAIT→IDLE on `Resolved & !Taken`.
- REDIRECT→IDLE unconditionally, after one cycle.
- WAIT with timeout counter == `BR_TIMEOUT` sets `O_Error` and stays in WAIT.
- `Resolved` seen in IDLE or REDIRECT: ignored, sets `O_Error`.

Outputs:
- `O_BranchStallSignal = (state==WAIT) | (issue & I_DE_IsBranch)`. The combinational term stops fetch in the same cycle the branch issues.
- `O_BranchAddrSelect = (state==REDIRECT)`.
- `O_Error` clears only on reset.

## Timing
- Reset (`I_LOCK` low, asynchronous) sets:
  - all `cnt` to 0;
  - state to IDLE;
  - `O_BranchPC` to 0, `O_BranchAddrSelect` to 0, `O_Error` to 0.
- Combinational stall outputs therefore read 0 during reset unless `I_DE_Valid` is asserted.
- Outputs settle after posedge; fetch samples them at the following negedge (half-cycle margin).
- Dependency stall: zero-cycle response to decode inputs. A retirement at posedge N releases the stall after posedge N.
- Branch penalty:
  - issue at cycle 0;
  - resolve pulse at cycle K;
  - taken: REDIRECT in cycle K+1, fetch resumes at the target;
  - not taken: IDLE in cycle K+1, fetch resumes sequentially.
- Reset asserted mid-WAIT or mid-REDIRECT: immediate return to IDLE, no redirect issued.

## Structure
- Shared package / `global_def.h` holds:
  - `PC_WIDTH`, `REG_IDX_W`, `NUM_REGS`;
  - FSM state encodings `BR_IDLE=2'd0`, `BR_WAIT=2'd1`, `BR_REDIRECT=2'd2`.
- One sub-module, `reg_scoreboard`: the counter array with inc/dec ports and three read ports. The branch FSM and timeout counter stay in the top level.

## Test plan
- Dependency:
  - issue R3 write; next decode reads R3;
  - expect `O_DepStallSignal`=1 until the cycle after `I_WB_Valid` with R3; `cnt[3]` goes 1→0.
- Simultaneous issue and retire:
  - issue write R5 while WB retires R5 with `cnt[5]`=1;
  - expect `cnt[5]` stays 1 and no stall on an independent instruction.
- Saturation:
  - issue three R7 writers with no retire;
  - expect the fourth R7-writer stalls and `cnt[7]`=3 never wraps.
- Taken branch:
  - branch issued cycle 0; Resolved+Taken, Target=16'h0040 at cycle 3;
  - expect BranchStall=1 in cycles 0-3, AddrSelect=1 and `O_BranchPC`=0x0040 in cycle 4 only.
- Not-taken branch and spurious resolve:
  - not-taken resolve: IDLE next cycle, AddrSelect never 1;
  - Resolved pulse in IDLE: `O_Error`=1, sticky until `I_LOCK` low.
- Reset and timeout:
  - `I_LOCK` low in WAIT: state IDLE and all counters 0 immediately;
  - no resolve for 15 cycles: `O_Error`=1.
